// File: rtl/fifo_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sram_ctrl
// Brief    : Single-clock FIFO controller for a dual-port SRAM.
//            Port1 is used for pushes and port2 for pops.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sram_ctrl #(
  parameter int A_LENGTH = 3,
  parameter int D_LENGTH = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [D_LENGTH-1:0] wr_data,
  input  logic                pop,
  output logic                full,
  output logic                almost_full,
  output logic                empty,
  output logic [A_LENGTH:0]   count,
  output logic                rd_valid,
  output logic [D_LENGTH-1:0] rd_data,
  output logic                overflow,
  output logic                underflow,
  output logic                sram_en_p1,
  output logic                sram_ctrl_p1,
  output logic [A_LENGTH-1:0] sram_addr_p1,
  output logic [D_LENGTH-1:0] sram_wdata_p1,
  output logic                sram_en_p2,
  output logic                sram_ctrl_p2,
  output logic [A_LENGTH-1:0] sram_addr_p2,
  input  logic [D_LENGTH-1:0] sram_rdata_p2
);

  localparam int                  c_PTR_W    = A_LENGTH + 1;
  localparam logic [A_LENGTH-1:0] c_PARK_XOR = A_LENGTH'(1);

  generate
    if (DEPTH != (1 << A_LENGTH)) begin : g_depth_check
      $error("DEPTH must equal 2**A_LENGTH");
    end
  endgenerate

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_count;
  logic               r_rd_valid;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;

  // Flags come from registered pointers only, so push/pop never reach them.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[A_LENGTH-1:0] == r_rd_ptr[A_LENGTH-1:0]) &&
                   (r_wr_ptr[A_LENGTH] != r_rd_ptr[A_LENGTH]);

  assign w_wr_acc = push & ~w_full;
  assign w_rd_acc = pop & ~w_empty;

  // An idle read port is parked one word away from the read pointer; when empty
  // the write pointer sits on that word, and the SRAM would drop a write on an
  // address match.
  assign sram_en_p1    = w_wr_acc;
  assign sram_ctrl_p1  = 1'b1;
  assign sram_addr_p1  = r_wr_ptr[A_LENGTH-1:0];
  assign sram_wdata_p1 = wr_data;
  assign sram_en_p2    = w_rd_acc;
  assign sram_ctrl_p2  = 1'b0;
  assign sram_addr_p2  = w_rd_acc ? r_rd_ptr[A_LENGTH-1:0]
                                  : (r_rd_ptr[A_LENGTH-1:0] ^ c_PARK_XOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_PTR_W'(1);
        2'b01:   r_count <= r_count - c_PTR_W'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= push & w_full;
      r_underflow <= pop & w_empty;
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign almost_full = (r_count >= c_PTR_W'(AF_LEVEL));
  assign rd_valid    = r_rd_valid;
  assign rd_data     = sram_rdata_p2;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sram_ctrl
// Brief    : Scoreboard bench for fifo_sram_ctrl with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sram_ctrl;

  localparam int A  = 3;
  localparam int D  = 8;
  localparam int N  = 8;
  localparam int AF = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push;
  logic [D-1:0] wr_data;
  logic         pop;
  logic         full, almost_full, empty, rd_valid, overflow, underflow;
  logic [A:0]   count;
  logic [D-1:0] rd_data;
  logic         sram_en_p1, sram_ctrl_p1, sram_en_p2, sram_ctrl_p2;
  logic [A-1:0] sram_addr_p1, sram_addr_p2;
  logic [D-1:0] sram_wdata_p1;
  logic [D-1:0] sram_rdata_p2;

  logic [D-1:0] mem [0:N-1];
  logic [D-1:0] model_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sram_ctrl #(.A_LENGTH(A), .D_LENGTH(D), .DEPTH(N), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
    .full(full), .almost_full(almost_full), .empty(empty), .count(count),
    .rd_valid(rd_valid), .rd_data(rd_data), .overflow(overflow), .underflow(underflow),
    .sram_en_p1(sram_en_p1), .sram_ctrl_p1(sram_ctrl_p1), .sram_addr_p1(sram_addr_p1),
    .sram_wdata_p1(sram_wdata_p1), .sram_en_p2(sram_en_p2), .sram_ctrl_p2(sram_ctrl_p2),
    .sram_addr_p2(sram_addr_p2), .sram_rdata_p2(sram_rdata_p2)
  );

  // Dual-port SRAM with registered read; an address match turns both ports into reads.
  always @(posedge clk) begin
    if (sram_en_p1 && sram_ctrl_p1 &&
        !(sram_en_p2 && sram_addr_p1 == sram_addr_p2))
      mem[sram_addr_p1] <= sram_wdata_p1;
    if (sram_en_p2 && !sram_ctrl_p2)
      sram_rdata_p2 <= mem[sram_addr_p2];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle of stimulus, called at a negedge; scoreboard compare at the next negedge.
  task automatic cyc(input logic p, input logic [D-1:0] d, input logic q);
    logic         wa, ra, exp_ovf, exp_unf;
    logic [D-1:0] expd;
    int           n;
    n       = model_q.size();
    wa      = p && (n < N);
    ra      = q && (n > 0);
    exp_ovf = p && (n == N);
    exp_unf = q && (n == 0);
    expd    = '0;
    push = p; wr_data = d; pop = q;
    #1;
    checks++;
    if (sram_en_p1 !== wa || sram_en_p2 !== ra) begin
      errors++;
      $display("FAIL sram_en: got p1=%b p2=%b, expected p1=%b p2=%b", sram_en_p1, sram_en_p2, wa, ra);
    end
    if (wa) begin
      checks++;
      if (sram_en_p2 && sram_addr_p1 == sram_addr_p2) begin
        errors++;
        $display("FAIL addr_collision: p1=%0d p2=%0d during write", sram_addr_p1, sram_addr_p2);
      end
    end
    if (ra) expd = model_q.pop_front();
    if (wa) model_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    checks++;
    if (rd_valid !== ra) begin
      errors++;
      $display("FAIL rd_valid: got %b expected %b", rd_valid, ra);
    end
    if (ra) begin
      checks++;
      if (rd_data !== expd) begin
        errors++;
        $display("FAIL rd_data: got %h expected %h", rd_data, expd);
      end
    end
    checks++;
    if (overflow !== exp_ovf || underflow !== exp_unf) begin
      errors++;
      $display("FAIL err_pulse: got ovf=%b unf=%b expected ovf=%b unf=%b",
               overflow, underflow, exp_ovf, exp_unf);
    end
    checks++;
    if (count !== (A+1)'(model_q.size()) || full !== (model_q.size() == N) ||
        empty !== (model_q.size() == 0) || almost_full !== (model_q.size() >= AF)) begin
      errors++;
      $display("FAIL flags: got cnt=%0d f=%b af=%b e=%b expected cnt=%0d", count, full,
               almost_full, empty, model_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: cnt=%0d e=%b f=%b af=%b v=%b o=%b u=%b", count, empty,
               full, almost_full, rd_valid, overflow, underflow);
    end
    checks++;
    if (sram_en_p1 !== 1'b0 || sram_en_p2 !== 1'b0 || sram_addr_p1 !== 3'd0 ||
        sram_addr_p2 !== 3'd1 || sram_ctrl_p1 !== 1'b1 || sram_ctrl_p2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_sram: en1=%b en2=%b a1=%0d a2=%0d expected 0 0 0 1",
               sram_en_p1, sram_en_p2, sram_addr_p1, sram_addr_p2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL basic_end: empty=%b count=%0d expected 1 0", empty, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d expected 1 8", full, count);
    end
    cyc(1'b1, 8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d expected 1 8", overflow, count);
    end
  endtask

  task automatic test_full_push_pop();
    cyc(1'b1, 8'hFF, 1'b1);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd7 || rd_data !== 8'hA0) begin
      errors++;
      $display("FAIL full_pp: ovf=%b count=%0d data=%h expected 1 7 a0", overflow, count, rd_data);
    end
    while (model_q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_empty_push_pop();
    cyc(1'b1, 8'h5A, 1'b1);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL empty_pp: unf=%b count=%0d expected 1 1", underflow, count);
    end
    cyc(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL empty_pp_data: got %h expected 5a", rd_data);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h40 + 8'(i), 1'b1);
      checks++;
      if (full !== 1'b0 || empty !== 1'b0 || count !== 4'd3) begin
        errors++;
        $display("FAIL wrap_flags: f=%b e=%b cnt=%0d expected 0 0 3", full, empty, count);
      end
    end
    while (model_q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    checks++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 ||
        sram_en_p1 !== 1'b0 || sram_en_p2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: v=%b cnt=%0d e=%b en1=%b en2=%b expected 0 0 1 0 0",
               rd_valid, count, empty, sram_en_p1, sram_en_p2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: v=%b e=%b expected 0 1", rd_valid, empty);
    end
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
